puf_challenge_sequencer: RTL
============================

// Module: puf_challenge_sequencer
// PURPOSE
//   Initiator side of the arbiter-PUF interface. It generates a sequence of
//   challenges from an LFSR, fires one launch pulse per challenge and samples
//   the asynchronous arbiter response through a 2-flop synchronizer.
//   It assembles RESP_BITS response bits into a word and returns the word with
//   a valid/ready handshake. It sits between the user I/O logic and arbiterpuf.
// PARAMETERS
//   CHAL_W        8      challenge width; must equal the delay-line length.
//   TAPS          8'hB8  Galois LFSR feedback mask (x^8+x^6+x^5+x^4+1).
//   RESP_BITS     8      response bits collected per run (1..32).
//   SETTLE_CYCLES 4      cycles with ipulse=0 after each challenge update (>=1).
//   PULSE_CYCLES  3      cycles with ipulse=1 per bit (>=3; covers sync latency).
// PORTS
//   clk         in   1          single clock; all logic on posedge.
//   rst         in   1          synchronous reset, active-high.
//   start       in   1          run request; sampled only in IDLE.
//   seed        in   CHAL_W     first challenge; 0 is replaced by 1.
//   busy        out  1          high in ARM or PULSE.
//   ipulse      out  1          launch pulse to the PUF (registered).
//   ichallenge  out  CHAL_W     challenge to the PUF (registered LFSR state).
//   oresponse   in   1          arbiter output; asynchronous to clk.
//   resp_word   out  RESP_BITS  assembled response; first bit lands in MSB.
//   resp_valid  out  1          resp_word is complete and stable.
//   resp_ready  in   1          consumer accepts resp_word.
// BEHAVIOUR
//   Reset: state=IDLE. ipulse, busy, resp_valid, resp_word, bit counter, cycle
//     counter and sync flops are all 0. ichallenge=1.
//   Sync: oresponse -> s1 -> s2 (2 flops). Only s2 is used.
//   LFSR step: lfsr <= lfsr[0] ? (lfsr>>1)^TAPS : lfsr>>1.
//   IDLE: on start=1, ichallenge<=(seed==0 ? 1 : seed), cnt<=0, bits<=0,
//     resp_word<=0, go to ARM. Otherwise hold all outputs.
//   ARM: ipulse=0 for exactly SETTLE_CYCLES cycles, then go to PULSE.
//   PULSE: ipulse=1 for exactly PULSE_CYCLES cycles.
//     On the last PULSE cycle: resp_word<={resp_word[RESP_BITS-2:0], s2},
//     bits<=bits+1, and ipulse drops to 0 at the next edge.
//     If bits+1==RESP_BITS, go to DONE. Otherwise advance the LFSR and go to ARM.
//     The ARM period therefore doubles as the pulse-release time.
//   DONE: resp_valid=1 and resp_word is frozen.
//     On resp_ready=1: resp_valid<=0, go to IDLE.
//     resp_word keeps its value until the next accepted start.
//   Per bit: SETTLE_CYCLES+PULSE_CYCLES cycles.
//     resp_valid rises RESP_BITS*(SETTLE_CYCLES+PULSE_CYCLES) cycles after the
//     edge that accepts start.
//   start is ignored in ARM, PULSE and DONE, including the DONE handshake cycle.
//     There is no queuing.
//   rst at any point, including mid-pulse: next edge forces ipulse=0 and
//     returns to the reset state. No partial word is presented.
//   The counters are sized to hold max(SETTLE_CYCLES, PULSE_CYCLES) and
//     RESP_BITS without wrap. The LFSR never reaches 0 because the seed-0
//     case is substituted.
// TESTING (CHAL_W=8, RESP_BITS=8, SETTLE=4, PULSE=3)
//   1. Assert rst for 2 cycles -> ipulse=0, busy=0, resp_valid=0,
//      resp_word=0x00, ichallenge=0x01.
//   2. seed=0x00, start 1 cycle, oresponse=1 -> challenges 0x01, 0xB8, ...;
//      resp_word=0xFF; resp_valid after 56 cycles; ipulse high 3 of every 7.
//   3. oresponse driven per bit 1,0,1,1,0,0,1,0 (changed during ARM)
//      -> resp_word=0xB2.
//   4. resp_ready held low 10 cycles in DONE -> resp_valid and resp_word
//      stable; ready=1 -> IDLE next cycle.
//   5. start pulsed during PULSE and during the DONE handshake -> no new run,
//      challenge sequence unaffected.
//   6. rst asserted in the 2nd PULSE cycle of bit 3 -> next edge ipulse=0,
//      busy=0, resp_valid=0. A fresh start runs the full 56 cycles.

Source files
------------

// File: rtl/puf_challenge_sequencer.sv
// puf_challenge_sequencer
// Initiator side of the arbiter-PUF link. Walks a Galois LFSR through a
// sequence of challenges, fires one launch pulse per challenge, samples the
// asynchronous arbiter response through a two-flop synchronizer and assembles
// RESP_BITS bits (first bit in the MSB) into a word returned via valid/ready.
module puf_challenge_sequencer #(
  parameter int                CHAL_W        = 8,
  parameter logic [CHAL_W-1:0] TAPS          = CHAL_W'(8'hB8),
  parameter int                RESP_BITS     = 8,
  parameter int                SETTLE_CYCLES = 4,
  parameter int                PULSE_CYCLES  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [CHAL_W-1:0]    seed,
  output logic                 busy,
  output logic                 ipulse,
  output logic [CHAL_W-1:0]    ichallenge,
  input  logic                 oresponse,
  output logic [RESP_BITS-1:0] resp_word,
  output logic                 resp_valid,
  input  logic                 resp_ready
);

  // The phase counter serves both ARM and PULSE, so it must hold the larger
  // of the two lengths; the bit counter must reach RESP_BITS without wrapping.
  localparam int CNT_MAX = (SETTLE_CYCLES > PULSE_CYCLES) ? SETTLE_CYCLES : PULSE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int BIT_W   = $clog2(RESP_BITS + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_PULSE,
    ST_DONE
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_W-1:0]       bits_q, bits_d;
  logic [BIT_W-1:0]       bits_inc;
  logic [CHAL_W-1:0]      lfsr_q, lfsr_d;
  logic [CHAL_W-1:0]      lfsr_next;
  logic [RESP_BITS-1:0]   word_q, word_d;
  logic                   valid_q, valid_d;
  logic                   busy_q, busy_d;
  logic                   ipulse_q, ipulse_d;
  logic                   s1_q, s1_d;
  logic                   s2_q, s2_d;

  assign bits_inc  = bits_q + BIT_W'(1);
  assign lfsr_next = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);

  // Next-state logic: sequencing of settle/pulse phases, bit capture and handshake.
  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    bits_d   = bits_q;
    lfsr_d   = lfsr_q;
    word_d   = word_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    ipulse_d = ipulse_q;
    s1_d     = oresponse;
    s2_d     = s1_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          // A zero seed would lock the LFSR at zero forever.
          lfsr_d   = (seed == '0) ? CHAL_W'(1) : seed;
          cnt_d    = '0;
          bits_d   = '0;
          word_d   = '0;
          busy_d   = 1'b1;
          ipulse_d = 1'b0;
          state_d  = ST_ARM;
        end
      end

      ST_ARM: begin
        // Challenge settles (and the previous pulse releases) with ipulse low.
        if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
          cnt_d    = '0;
          ipulse_d = 1'b1;
          state_d  = ST_PULSE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_PULSE: begin
        if (cnt_q == CNT_W'(PULSE_CYCLES - 1)) begin
          // Pulse length covers the synchronizer latency, so s2 is the
          // arbiter decision for this challenge.
          cnt_d     = '0;
          ipulse_d  = 1'b0;
          word_d    = word_q << 1;
          word_d[0] = s2_q;
          bits_d    = bits_inc;
          if (bits_inc == BIT_W'(RESP_BITS)) begin
            busy_d  = 1'b0;
            valid_d = 1'b1;
            state_d = ST_DONE;
          end else begin
            lfsr_d  = lfsr_next;
            state_d = ST_ARM;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        // Word stays frozen; start is deliberately not looked at here.
        if (resp_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous reset; reset drops ipulse immediately.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bits_q   <= '0;
      lfsr_q   <= CHAL_W'(1);
      word_q   <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      ipulse_q <= 1'b0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bits_q   <= bits_d;
      lfsr_q   <= lfsr_d;
      word_q   <= word_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      ipulse_q <= ipulse_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
    end
  end

  assign busy       = busy_q;
  assign ipulse     = ipulse_q;
  assign ichallenge = lfsr_q;
  assign resp_word  = word_q;
  assign resp_valid = valid_q;

endmodule
